interrupt_controller: RTL
=========================

Name: interrupt_controller

Overview:
- Prioritised interrupt controller (CP0-style) for the single-cycle MIPS core.
- Latches edge-triggered requests from NUM_SRC sources and applies a software mask.
- Picks the highest-priority eligible source and redirects the PC fetch mux to that source's entrance vector for one cycle.
- Saves the return PC in EPC and restores it on eret. It sits between the I/O request lines and the pc_in selection logic.

Parameters:
- NUM_SRC, 3, number of interrupt sources; index NUM_SRC-1 has the highest priority.
- VEC0, 32'h0000_0400, entrance vector for source 0.
- VEC1, 32'h0000_0800, entrance vector for source 1.
- VEC2, 32'h0000_0C00, entrance vector for source 2.

Ports:
- clk  in  1  core clock, the same gated clock that drives the pc register.
- rst  in  1  synchronous, active-high reset.
- irq_in  in  NUM_SRC  raw request lines, level-held by devices.
- mask_we  in  1  write strobe for the mask register.
- mask_din  in  NUM_SRC  new mask; 1 = source enabled.
- pc_next  in  32  PC the core would fetch next with no interrupt.
- eret  in  1  exception-return instruction is executing this cycle.
- halt  in  1  core halted; no interrupt is taken.
- take  out  1  redirect pulse; pc_in = vector this cycle.
- vector  out  32  entrance address of the source being taken.
- epc  out  32  return address; the core uses it for pc_next on eret.
- in_service  out  NUM_SRC  one-hot-or-zero set of sources being serviced.
- pending  out  NUM_SRC  latched, not-yet-taken requests.
- mask  out  NUM_SRC  current mask register.

Behaviour:
- Reset (synchronous, on clk rising edge with rst=1) clears:
  - take=0, vector=0, epc=0, in_service=0, pending=0, mask=0.
  - Edge-detect history cleared; FSM returns to IDLE.
  - Reset mid-service discards all context.
- Edge detect:
  - pending[i] sets on the rising edge of irq_in[i], meaning prev=0 and now=1 sampled on clk.
  - A level held high sets pending only once.
- pending[i] clears only when source i is taken or on rst. If a new edge and the take of the same source coincide, pending stays clear; that edge is lost by design.
- mask_we updates mask on the next edge and takes effect the cycle after the write. Masking a pending source keeps pending set.
- eligible = pending & mask. The winner is the highest set index of eligible.
- FSM states: IDLE, TAKE, SERVICE.
  - IDLE: if eligible!=0 and halt=0, go to TAKE.
  - TAKE (exactly one cycle):
    - take=1 and vector=VEC[winner], combinational from the registered winner.
    - On the edge: epc<=pc_next, in_service[winner]<=1, pending[winner]<=0, go to SERVICE.
  - SERVICE: further sources stay pending and are not taken. On eret: in_service<=0, go to IDLE. The epc value remains readable during the eret cycle.
- Latency: a request edge sampled on edge N drives take=1 during the cycle after edge N+1, i.e. 2 cycles.
- Simultaneous eret and a pending request in SERVICE: eret completes first. The controller returns to IDLE, and the pending request goes to TAKE on the following edge.
- eret in IDLE or TAKE is ignored, with no state change.
- halt=1 blocks entry to TAKE. A TAKE already in progress completes.
- The winner is registered on IDLE->TAKE so that vector is stable throughout TAKE.

Optional Feature:
- Macro: IRQ_NESTING_EN.
- Defined:
  - In SERVICE, an eligible source whose priority is strictly higher than the current in_service maximum causes a preempting TAKE.
  - The old epc is pushed onto an internal EPC stack of depth NUM_SRC-1, and in_service may hold several bits.
  - eret clears only the highest in_service bit and pops the stack into epc. The FSM stays in SERVICE until in_service==0.
  - Equal or lower priority waits.
- Undefined: the behaviour is strictly non-nesting, as above, and no stack is instantiated.

Decomposition:
- Package irq_pkg holds:
  - localparams NUM_SRC_DEFAULT and the VEC0..VEC2 defaults.
  - The state enum (IDLE/TAKE/SERVICE) as 2-bit constants.
  - A function for the highest-set-index priority encode.
- One sub-module, irq_edge_latch, holds the per-source prev register plus the pending set/clear logic, instantiated NUM_SRC times.

Test Plan:
- Reset then irq_in=3'b001, mask=3'b111, pc_next=0x20 -> take=1 two cycles later, vector=0x400, epc=0x20, in_service=3'b001, pending=0.
- irq_in=3'b101 on the same edge, mask=3'b111 -> source 2 is taken first (vector=0xC00); pending=3'b001 remains. After eret, source 0 is taken with vector=0x400.
- mask=3'b000, pulse irq_in[1] -> pending=3'b010 and no take. Write mask=3'b010 -> take follows with vector=0x800.
- irq_in[0] held high for 10 cycles -> exactly one take. eret then yields no further take until irq_in falls and rises again.
- In SERVICE for source 0, assert rst -> all outputs return to zero on the next edge and the FSM is in IDLE; a later eret has no effect.
- IRQ_NESTING_EN: while servicing source 0 with epc=0x20, raise source 2 with pc_next=0x404 -> take with vector=0xC00, epc=0x404, in_service=3'b101. The first eret gives epc=0x20 and in_service=3'b001; the second eret gives IDLE.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared definitions for the interrupt controller: default geometry,
// entrance vectors, FSM state encoding and the priority encoder.
package irq_pkg;

  localparam int          NUM_SRC_DEFAULT = 3;
  localparam logic [31:0] VEC0_DEFAULT    = 32'h0000_0400;
  localparam logic [31:0] VEC1_DEFAULT    = 32'h0000_0800;
  localparam logic [31:0] VEC2_DEFAULT    = 32'h0000_0C00;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_TAKE    = 2'd1,
    ST_SERVICE = 2'd2
  } irq_state_e;

  // Index of the highest set bit (highest index = highest priority);
  // returns 0 for an all-zero input, so callers test for "any" separately.
  function automatic logic [4:0] prio_enc(input logic [31:0] v);
    logic [4:0] idx;
    idx = '0;
    for (int i = 0; i < 32; i++) begin
      if (v[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/interrupt_controller_if.sv
// Bus between the core / I/O request lines and the interrupt controller.
// master: core side (drives requests, mask writes, pc_next, eret, halt).
// slave : the controller itself.
interface interrupt_controller_if #(
  parameter int NUM_SRC = irq_pkg::NUM_SRC_DEFAULT
);
  logic [NUM_SRC-1:0] irq_in;
  logic               mask_we;
  logic [NUM_SRC-1:0] mask_din;
  logic [31:0]        pc_next;
  logic               eret;
  logic               halt;
  logic               take;
  logic [31:0]        vector;
  logic [31:0]        epc;
  logic [NUM_SRC-1:0] in_service;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] mask;

  modport master (
    output irq_in, mask_we, mask_din, pc_next, eret, halt,
    input  take, vector, epc, in_service, pending, mask
  );

  modport slave (
    input  irq_in, mask_we, mask_din, pc_next, eret, halt,
    output take, vector, epc, in_service, pending, mask
  );
endinterface

// File: rtl/irq_edge_latch.sv
// Per-source rising-edge detector with a sticky pending flag.
// A clear coinciding with a new edge wins: that edge is dropped.
module irq_edge_latch (
  input  logic clk,
  input  logic rst,
  input  logic irq_i,
  input  logic clr_i,
  output logic pending_o
);

  logic prev_q;
  logic pending_q, pending_d;

  // Next pending: clear beats set, set on 0->1 of the sampled line
  always_comb begin
    pending_d = pending_q;
    if (clr_i)               pending_d = 1'b0;
    else if (irq_i && !prev_q) pending_d = 1'b1;
  end

  // History and pending registers
  always_ff @(posedge clk) begin
    if (rst) begin
      prev_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      prev_q    <= irq_i;
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;

endmodule

// File: rtl/interrupt_controller.sv
// Prioritised, CP0-style interrupt controller for the single-cycle core.
// Latches request edges, masks them, and on a take redirects the PC fetch
// mux to the winner's vector for one cycle while saving the return PC.
// Optional macro IRQ_NESTING_EN: strictly-higher-priority preemption with
// an EPC stack of depth NUM_SRC-1; undefined = non-nesting, no stack.
module interrupt_controller
  import irq_pkg::*;
#(
  parameter int          NUM_SRC = NUM_SRC_DEFAULT,
  parameter logic [31:0] VEC0    = VEC0_DEFAULT,
  parameter logic [31:0] VEC1    = VEC1_DEFAULT,
  parameter logic [31:0] VEC2    = VEC2_DEFAULT
) (
  input logic                  clk,
  input logic                  rst,
  interrupt_controller_if.slave bus
);

  localparam int IDX_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

  irq_state_e         state_q, state_d;
  logic [IDX_W-1:0]   winner_q, winner_d;
  logic [31:0]        epc_q, epc_d;
  logic [NUM_SRC-1:0] in_service_q, in_service_d;
  logic [NUM_SRC-1:0] mask_q, mask_d;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] eligible;
  logic [NUM_SRC-1:0] win_oh;
  logic [NUM_SRC-1:0] clr;
  logic [4:0]         elig_win;
  logic               elig_any;
  logic               taking;
  logic               eret_svc;

  function automatic logic [31:0] vec_of(input logic [IDX_W-1:0] idx);
    case (int'(idx))
      0:       return VEC0;
      1:       return VEC1;
      2:       return VEC2;
      default: return 32'h0;
    endcase
  endfunction

  assign eligible = pending & mask_q;
  assign elig_any = |eligible;
  assign elig_win = prio_enc(32'(eligible));
  assign taking   = (state_q == ST_TAKE);
  assign eret_svc = (state_q == ST_SERVICE) && bus.eret;

  // One-hot of the registered winner; drives the pending clear on take
  always_comb begin
    win_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) win_oh[i] = (int'(winner_q) == i);
  end

  assign clr = taking ? win_oh : '0;

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
    irq_edge_latch u_latch (
      .clk       (clk),
      .rst       (rst),
      .irq_i     (bus.irq_in[g]),
      .clr_i     (clr[g]),
      .pending_o (pending[g])
    );
  end

`ifdef IRQ_NESTING_EN
  localparam int STK_D  = (NUM_SRC > 1) ? NUM_SRC - 1 : 1;
  localparam int STK_IW = (STK_D > 1) ? $clog2(STK_D) : 1;
  localparam int SP_W   = $clog2(STK_D + 1);

  logic [31:0]        stk_q [STK_D];
  logic [SP_W-1:0]    sp_q, sp_d;
  logic [4:0]         svc_top;
  logic [NUM_SRC-1:0] svc_oh;
  logic [NUM_SRC-1:0] svc_left;
  logic               preempt;
  logic               push;
  logic               pop;

  assign svc_top = prio_enc(32'(in_service_q));

  // One-hot of the highest source currently in service
  always_comb begin
    svc_oh = '0;
    for (int i = 0; i < NUM_SRC; i++) svc_oh[i] = (int'(svc_top) == i);
  end

  assign svc_left = in_service_q & ~svc_oh;
  assign preempt  = elig_any && !bus.halt && (elig_win > svc_top);
  assign push     = taking && (in_service_q != '0);
  assign pop      = eret_svc && (sp_q != '0);

  // Stack pointer next state
  always_comb begin
    sp_d = sp_q;
    if (push)     sp_d = sp_q + SP_W'(1);
    else if (pop) sp_d = sp_q - SP_W'(1);
  end

  // Stack pointer register
  always_ff @(posedge clk) begin
    if (rst) sp_q <= '0;
    else     sp_q <= sp_d;
  end

  // EPC stack storage; contents are meaningless below an empty pointer
  always_ff @(posedge clk) begin
    if (push) stk_q[STK_IW'(sp_q)] <= epc_q;
  end
`endif

  // FSM next state and winner capture
  always_comb begin
    state_d  = state_q;
    winner_d = winner_q;
    case (state_q)
      ST_IDLE: begin
        if (elig_any && !bus.halt) begin
          state_d  = ST_TAKE;
          winner_d = IDX_W'(elig_win);
        end
      end
      ST_TAKE: state_d = ST_SERVICE;
      ST_SERVICE: begin
`ifdef IRQ_NESTING_EN
        if (bus.eret) begin
          if (svc_left == '0) state_d = ST_IDLE;
        end else if (preempt) begin
          state_d  = ST_TAKE;
          winner_d = IDX_W'(elig_win);
        end
`else
        if (bus.eret) state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // EPC, in-service set and mask next state
  always_comb begin
    epc_d        = epc_q;
    in_service_d = in_service_q;
    mask_d       = bus.mask_we ? bus.mask_din : mask_q;
    if (taking) begin
      epc_d        = bus.pc_next;
      in_service_d = in_service_q | win_oh;
    end else if (eret_svc) begin
`ifdef IRQ_NESTING_EN
      in_service_d = svc_left;
      if (pop) epc_d = stk_q[STK_IW'(sp_q - SP_W'(1))];
`else
      in_service_d = '0;
`endif
    end
  end

  // Control and context registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      winner_q     <= '0;
      epc_q        <= '0;
      in_service_q <= '0;
      mask_q       <= '0;
    end else begin
      state_q      <= state_d;
      winner_q     <= winner_d;
      epc_q        <= epc_d;
      in_service_q <= in_service_d;
      mask_q       <= mask_d;
    end
  end

  assign bus.take       = taking;
  assign bus.vector     = taking ? vec_of(winner_q) : 32'h0;
  assign bus.epc        = epc_q;
  assign bus.in_service = in_service_q;
  assign bus.pending    = pending;
  assign bus.mask       = mask_q;

endmodule
